dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of an async-read, sync-write data memory.
// Latency: a request sampled in IDLE is acknowledged in the next cycle, and the ack is combinational from state.
// Backpressure: requesters hold req and operands until their ack. The memory never stalls, and contention alternates at full rate.
//
// Ports:
//   clk, reset_n            rising-edge clock, asynchronous active-low reset
//   req0/1, we0/1           transaction request, write enable (1 = write)
//   addr0/1, wdata0/1       byte address (passed through unmodified) and write data
//   ack0/1                  one-cycle completion pulse (write committed / rdata valid)
//   rdata                   read data, nonzero only while an ack is high
//   mem_we/addr/wdata       memory command, driven from registered operands
//   mem_rdata               combinational read data from the memory
//   busy                    high while a transaction is in its access cycle
//   gnt_cnt0/1              saturating grant counters, present only when
//                           DMEM_ARB_PERF_EN is defined
module dmem_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [15:0] gnt_cnt0,
    output logic [15:0] gnt_cnt1
`endif
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS0 = 2'd1;
    localparam logic [1:0] ST_ACCESS1 = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        last_gnt_q, last_gnt_d;   // 1 = requester 1 was granted last
    logic        op_we_q, op_we_d;
    logic [31:0] op_addr_q, op_addr_d;
    logic [31:0] op_wdata_q, op_wdata_d;
    logic        grant0, grant1;

    // Winner selection. In an access state, only the other requester can be
    // granted. This gives alternation under contention and caps a lone
    // requester at one transaction every two cycles.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0 && req1) begin
                    grant0 = last_gnt_q;
                    grant1 = ~last_gnt_q;
                end else begin
                    grant0 = req0;
                    grant1 = req1;
                end
            end
            ST_ACCESS0: grant1 = req1;
            ST_ACCESS1: grant0 = req0;
            default: ;
        endcase
    end

    always_comb begin
        state_d    = ST_IDLE;
        last_gnt_d = last_gnt_q;
        op_we_d    = op_we_q;
        op_addr_d  = op_addr_q;
        op_wdata_d = op_wdata_q;
        if (grant0) begin
            state_d    = ST_ACCESS0;
            last_gnt_d = 1'b0;
            op_we_d    = we0;
            op_addr_d  = addr0;
            op_wdata_d = wdata0;
        end else if (grant1) begin
            state_d    = ST_ACCESS1;
            last_gnt_d = 1'b1;
            op_we_d    = we1;
            op_addr_d  = addr1;
            op_wdata_d = wdata1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= 1'b1;
            op_we_q    <= 1'b0;
            op_addr_q  <= 32'd0;
            op_wdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            op_we_q    <= op_we_d;
            op_addr_q  <= op_addr_d;
            op_wdata_q <= op_wdata_d;
        end
    end

    // All outputs decode from state, so an asynchronous reset in the middle
    // of a write drops mem_we before the commit edge.
    assign ack0      = (state_q == ST_ACCESS0);
    assign ack1      = (state_q == ST_ACCESS1);
    assign busy      = ack0 | ack1;
    assign mem_we    = busy & op_we_q;
    assign mem_addr  = busy ? op_addr_q  : 32'd0;
    assign mem_wdata = busy ? op_wdata_q : 32'd0;
    assign rdata     = busy ? mem_rdata  : 32'd0;

`ifdef DMEM_ARB_PERF_EN
    logic [15:0] gnt_cnt0_q, gnt_cnt1_q;

    // Counters only write on an increment, so they hold at 0xFFFF.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt_cnt0_q <= 16'd0;
            gnt_cnt1_q <= 16'd0;
        end else begin
            if (ack0 && (gnt_cnt0_q != 16'hFFFF)) gnt_cnt0_q <= gnt_cnt0_q + 16'd1;
            if (ack1 && (gnt_cnt1_q != 16'hFFFF)) gnt_cnt1_q <= gnt_cnt1_q + 16'd1;
        end
    end

    assign gnt_cnt0 = gnt_cnt0_q;
    assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table plus multi-cycle sequences.
// Inputs are driven on the falling edge, and outputs are sampled 1 ns later.
// A behavioural memory model sits on the mem_* port.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = 32'd0, addr1 = 32'd0, wdata0 = 32'd0, wdata1 = 32'd0;
    logic        ack0, ack1, mem_we, busy;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata     (rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
`ifdef DMEM_ARB_PERF_EN
        ,
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1)
`endif
    );

    // Memory model: async read, write on the rising edge. The bench preloads
    // words through the same process.
    logic [31:0] mem [0:63];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = 6'd0;
    logic [31:0] pre_dat = 32'd0;
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_we)      mem[mem_addr[7:2]] <= mem_wdata;
        else if (pre_en) mem[pre_idx]       <= pre_dat;
    end

    int ack0_seen = 0;
    always @(negedge clk) if (ack0) ack0_seen++;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [99:0] act, input logic [99:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [99:0] outs();
        return {ack0, ack1, busy, mem_we, mem_addr, mem_wdata, rdata};
    endfunction

    typedef struct {
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic [3:0]  ctl;      // {ack0, ack1, busy, mem_we}
        logic [31:0] e_addr, e_wdata, e_rdata;
    } vec_t;

    function automatic vec_t mk(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                                input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                                input logic [3:0] ctl, input logic [31:0] ea, input logic [31:0] ed,
                                input logic [31:0] er);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.ctl = ctl; v.e_addr = ea; v.e_wdata = ed; v.e_rdata = er;
        return v;
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] dat);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = idx; pre_dat = dat;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // Raise a read on one port and wait, with a cycle bound, for its ack.
    task automatic txn(input int p);
        bit ok = 1'b0;
        if (p == 0) begin req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; end
        else        begin req1 = 1'b1; we1 = 1'b0; addr1 = 32'h10; end
        for (int k = 0; k < 6 && !ok; k++) begin
            @(negedge clk); #1;
            if (p == 0 ? ack0 : ack1) ok = 1'b1;
        end
        req0 = 1'b0; req1 = 1'b0;
        check("txn_ack", {99'd0, ok}, 100'd1);
    endtask

    vec_t tbl [0:10];

    initial begin
        tbl[0]  = mk(0,0,32'h0,32'h0,         0,0,32'h0,32'h0,         4'b0000, 32'h0,  32'h0,        32'h0);
        tbl[1]  = mk(1,1,32'h10,32'hDEADBEEF, 0,0,32'h0,32'h0,         4'b0000, 32'h0,  32'h0,        32'h0);
        tbl[2]  = mk(1,1,32'h10,32'hDEADBEEF, 0,0,32'h0,32'h0,         4'b1011, 32'h10, 32'hDEADBEEF, 32'h0);
        tbl[3]  = mk(0,0,32'h0,32'h0,         1,0,32'h10,32'h0,        4'b0000, 32'h0,  32'h0,        32'h0);
        tbl[4]  = mk(0,0,32'h0,32'h0,         1,0,32'h10,32'h0,        4'b0110, 32'h10, 32'h0,        32'hDEADBEEF);
        tbl[5]  = mk(1,0,32'h10,32'h0,        1,1,32'h14,32'hCAFEF00D, 4'b0000, 32'h0,  32'h0,        32'h0);
        tbl[6]  = mk(1,0,32'h10,32'h0,        1,1,32'h14,32'hCAFEF00D, 4'b1010, 32'h10, 32'h0,        32'hDEADBEEF);
        tbl[7]  = mk(0,0,32'h0,32'h0,         1,1,32'h14,32'hCAFEF00D, 4'b0111, 32'h14, 32'hCAFEF00D, 32'h0);
        tbl[8]  = mk(1,0,32'h14,32'h0,        0,0,32'h0,32'h0,         4'b0000, 32'h0,  32'h0,        32'h0);
        tbl[9]  = mk(0,0,32'h0,32'h0,         0,0,32'h0,32'h0,         4'b1010, 32'h14, 32'h0,        32'hCAFEF00D);
        tbl[10] = mk(0,0,32'h0,32'h0,         0,0,32'h0,32'h0,         4'b0000, 32'h0,  32'h0,        32'h0);

        // Reset state, before any clock edge.
        #1;
        check("reset_outputs", outs(), 100'd0);
        preload(6'd4, 32'h0);
        preload(6'd5, 32'h0);
        preload(6'd8, 32'h55AA55AA);
        @(negedge clk);
        reset_n = 1'b1;

        // Table: write, read-back, tie after ack1, and a dropped req still served.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            req0 = tbl[i].r0; we0 = tbl[i].w0; addr0 = tbl[i].a0; wdata0 = tbl[i].d0;
            req1 = tbl[i].r1; we1 = tbl[i].w1; addr1 = tbl[i].a1; wdata1 = tbl[i].d1;
            #1;
            check($sformatf("vec%0d", i), outs(),
                  {tbl[i].ctl, tbl[i].e_addr, tbl[i].e_wdata, tbl[i].e_rdata});
        end
        check("mem_word4", {68'd0, mem[4]}, {68'd0, 32'hDEADBEEF});
        check("mem_word5", {68'd0, mem[5]}, {68'd0, 32'hCAFEF00D});

        // Contention after reset: ack0, ack1, ack0, ack1 with busy held high.
        pulse_reset();
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h14;
        #1;
        check("cont_idle", {97'd0, ack0, ack1, busy}, 100'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check($sformatf("cont%0d", i), {97'd0, ack0, ack1, busy},
                  (i % 2 == 0) ? 100'b101 : 100'b011);
        end
        req0 = 1'b0; req1 = 1'b0;

        // Lone requester: ack1 every second cycle, never ack0.
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h10;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("lone%0d", i), {98'd0, ack0, ack1},
                  (i % 2 == 1) ? 100'b01 : 100'b00);
            @(negedge clk);
        end
        req1 = 1'b0;

        // Reset during the access cycle of a write: no commit, no ack.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h12345678;
        @(negedge clk); #1;
        check("rst_pre_we", {99'd0, mem_we}, 100'd1);
        begin
            int seen;
            seen = ack0_seen;
            #1 reset_n = 1'b0;
            #1;
            check("rst_outputs_zero", outs(), 100'd0);
            req0 = 1'b0;
            @(negedge clk);
            @(negedge clk);
            reset_n = 1'b1;
            #1;
            check("rst_after_release", outs(), 100'd0);
            @(negedge clk); #1;
            check("rst_word8_kept", {68'd0, mem[8]}, {68'd0, 32'h55AA55AA});
            check("rst_no_ack0", 100'(ack0_seen - seen), 100'd0);
        end

`ifdef DMEM_ARB_PERF_EN
        pulse_reset();
        check("perf_reset", {68'd0, gnt_cnt0, gnt_cnt1}, 100'd0);
        for (int i = 0; i < 5; i++) txn(0);
        for (int i = 0; i < 3; i++) txn(1);
        @(negedge clk); #1;
        check("perf_cnt0", {84'd0, gnt_cnt0}, 100'd5);
        check("perf_cnt1", {84'd0, gnt_cnt1}, 100'd3);
        force dut.gnt_cnt0_q = 16'hFFFF;
        #1 release dut.gnt_cnt0_q;
        txn(0);
        @(negedge clk); #1;
        check("perf_saturate", {84'd0, gnt_cnt0}, 100'hFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
